// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM status, arbiter FSM states, requester indices.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    localparam int unsigned NUM_REQ = 4;

    localparam logic [1:0] REQ_D0 = 2'd0;
    localparam logic [1:0] REQ_I0 = 2'd1;
    localparam logic [1:0] REQ_D1 = 2'd2;
    localparam logic [1:0] REQ_I1 = 2'd3;

endpackage

// File: rtl/starve_counter.sv
// Saturating counter tracking how many data grants an icache has lost.
module starve_counter #(
    parameter int unsigned LIMIT = 8
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins over increment; hold once the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/ram_arbiter.sv
// Four-way RAM arbiter: data-over-instruction priority with starvation
// protection, per-class round-robin, one- or two-word transfers and a
// one-cycle bus turnaround between grants.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  blk,
    input  ramstate_t           ramstate,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [1:0]          gnt_id,
    output logic                beat,
    output logic                beat_done,
    output logic                xfer_done,
    output logic                err
);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [1:0]         gnt_id_q, gnt_id_d;
    logic               beat_q, beat_d;
    logic               blk_q, blk_d;
    logic               dptr_q, dptr_d;
    logic               iptr_q, iptr_d;

    logic               inc0, inc1, clr0, clr1;
    logic               sat0, sat1;
    logic               i0_starved, i1_starved;
    logic               win_valid, win_data;
    logic [1:0]         win_id;

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve_i0 (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (inc0),
        .clr  (clr0),
        .sat  (sat0)
    );

    starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve_i1 (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (inc1),
        .clr  (clr1),
        .sat  (sat1)
    );

    assign i0_starved = sat0 & req[REQ_I0];
    assign i1_starved = sat1 & req[REQ_I1];

    // Winner selection: starved icache, then data class, then instruction class.
    always_comb begin
        win_valid = |req;
        win_data  = 1'b0;
        win_id    = REQ_D0;
        if (i0_starved && i1_starved) begin
            win_id = iptr_q ? REQ_I1 : REQ_I0;
        end else if (i0_starved) begin
            win_id = REQ_I0;
        end else if (i1_starved) begin
            win_id = REQ_I1;
        end else if (req[REQ_D0] || req[REQ_D1]) begin
            win_data = 1'b1;
            if (req[REQ_D0] && req[REQ_D1]) begin
                win_id = dptr_q ? REQ_D1 : REQ_D0;
            end else begin
                win_id = req[REQ_D0] ? REQ_D0 : REQ_D1;
            end
        end else if (req[REQ_I0] && req[REQ_I1]) begin
            win_id = iptr_q ? REQ_I1 : REQ_I0;
        end else begin
            win_id = req[REQ_I0] ? REQ_I0 : REQ_I1;
        end
    end

    // Next-state, grant bookkeeping and per-cycle beat/abort strobes.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        beat_d    = beat_q;
        blk_d     = blk_q;
        dptr_d    = dptr_q;
        iptr_d    = iptr_q;
        beat_done = 1'b0;
        xfer_done = 1'b0;
        err       = 1'b0;
        inc0      = 1'b0;
        inc1      = 1'b0;
        clr0      = 1'b0;
        clr1      = 1'b0;
        case (state_q)
            IDLE: begin
                beat_d = 1'b0;
                if (win_valid) begin
                    state_d  = XFER;
                    gnt_d    = 4'b0001 << win_id;
                    gnt_id_d = win_id;
                    blk_d    = blk[win_id];
                    if (win_data) begin
                        dptr_d = (win_id == REQ_D0);
                        inc0   = req[REQ_I0];
                        inc1   = req[REQ_I1];
                    end else begin
                        iptr_d = (win_id == REQ_I0);
                        clr0   = (win_id == REQ_I0);
                        clr1   = (win_id == REQ_I1);
                    end
                end
            end
            XFER: begin
                if (!req[gnt_id_q]) begin
                    state_d = TURN;
                end else begin
                    case (ramstate)
                        ERROR: begin
                            err     = 1'b1;
                            state_d = TURN;
                        end
                        ACCESS: begin
                            beat_done = 1'b1;
                            if (blk_q && !beat_q) begin
                                beat_d = 1'b1;
                            end else begin
                                xfer_done = 1'b1;
                                state_d   = TURN;
                            end
                        end
                        default: ;
                    endcase
                end
                if (state_d == TURN) begin
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    beat_d   = 1'b0;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                beat_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            beat_q   <= 1'b0;
            blk_q    <= 1'b0;
            dptr_q   <= 1'b0;
            iptr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            beat_q   <= beat_d;
            blk_q    <= blk_d;
            dptr_q   <= dptr_d;
            iptr_q   <= iptr_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign beat   = beat_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: per-cycle vector table plus a hand-written
// mid-block reset sequence.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    logic       CLK;
    logic       nRST;
    logic [3:0] req;
    logic [3:0] blk;
    ramstate_t  ramstate;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       beat;
    logic       beat_done;
    logic       xfer_done;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    ram_arbiter #(.STARVE_LIMIT(2)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req       (req),
        .blk       (blk),
        .ramstate  (ramstate),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .beat      (beat),
        .beat_done (beat_done),
        .xfer_done (xfer_done),
        .err       (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] blk;
        ramstate_t  rs;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       beat;
        logic       bd;
        logic       xd;
        logic       er;
    } vec_t;

    vec_t vec[$];

    function automatic void add(bit rst, logic [3:0] r, logic [3:0] b, ramstate_t rs,
                                logic [3:0] g, logic [1:0] id, logic bt,
                                logic bd, logic xd, logic er);
        vec_t v;
        v.rst = rst; v.req = r; v.blk = b; v.rs = rs;
        v.gnt = g; v.id = id; v.beat = bt; v.bd = bd; v.xd = xd; v.er = er;
        vec.push_back(v);
    endfunction

    task automatic chk(input string nm, input int row, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b expected %b", nm, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input logic [3:0] g, input logic [1:0] id,
                           input logic bt, input logic bd, input logic xd, input logic er);
        chk("gnt",       row, gnt,               g);
        chk("gnt_id",    row, 4'(gnt_id),        4'(id));
        chk("beat",      row, 4'(beat),          4'(bt));
        chk("beat_done", row, 4'(beat_done),     4'(bd));
        chk("xfer_done", row, 4'(xfer_done),     4'(xd));
        chk("err",       row, 4'(err),           4'(er));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST     = 1'b0;
        req      = '0;
        blk      = '0;
        ramstate = FREE;

        // Reset state, including inputs that would otherwise grant/complete.
        add(1, 4'h0, 4'h0, FREE,   4'h0, 0, 0, 0, 0, 0);
        add(1, 4'hF, 4'hF, ACCESS, 4'h0, 0, 0, 0, 0, 0);
        // Two-word block for dcache0 with BUSY stalls.
        add(0, 4'b0001, 4'b0001, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0001, 4'b0001, BUSY,   4'b0001, 0, 0, 0, 0, 0);
        add(0, 4'b0001, 4'b0001, BUSY,   4'b0001, 0, 0, 0, 0, 0);
        add(0, 4'b0001, 4'b0001, ACCESS, 4'b0001, 0, 0, 1, 0, 0);
        add(0, 4'b0001, 4'b0001, BUSY,   4'b0001, 0, 1, 0, 0, 0);
        add(0, 4'b0001, 4'b0001, ACCESS, 4'b0001, 0, 1, 1, 1, 0);
        add(0, 4'b0000, 4'b0000, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, FREE,   4'h0,    0, 0, 0, 0, 0);
        // Data round-robin: D0, D1, D0.
        add(1, 4'h0, 4'h0, FREE, 4'h0, 0, 0, 0, 0, 0);
        add(0, 4'b0101, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0101, 4'h0, ACCESS, 4'b0001, 0, 0, 1, 1, 0);
        add(0, 4'b0101, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0101, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0101, 4'h0, ACCESS, 4'b0100, 2, 0, 1, 1, 0);
        add(0, 4'b0101, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0101, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0101, 4'h0, ACCESS, 4'b0001, 0, 0, 1, 1, 0);
        add(0, 4'b0000, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        // Starvation (limit 2): D0, D1, then forced icache0.
        add(1, 4'h0, 4'h0, FREE, 4'h0, 0, 0, 0, 0, 0);
        add(0, 4'b0111, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0111, 4'h0, ACCESS, 4'b0001, 0, 0, 1, 1, 0);
        add(0, 4'b0111, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0111, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0111, 4'h0, ACCESS, 4'b0100, 2, 0, 1, 1, 0);
        add(0, 4'b0111, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0111, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0111, 4'h0, ACCESS, 4'b0010, 1, 0, 1, 1, 0);
        add(0, 4'b0000, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        // ERROR abort on icache1 block, beat 0.
        add(1, 4'h0, 4'h0, FREE, 4'h0, 0, 0, 0, 0, 0);
        add(0, 4'b1000, 4'b1000, FREE,  4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b1000, 4'b1000, ERROR, 4'b1000, 3, 0, 0, 0, 1);
        add(0, 4'b0000, 4'b0000, FREE,  4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, FREE,  4'h0,    0, 0, 0, 0, 0);
        // Requester withdraws after one BUSY cycle; ACCESS that cycle is ignored.
        add(1, 4'h0, 4'h0, FREE, 4'h0, 0, 0, 0, 0, 0);
        add(0, 4'b0010, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0010, 4'h0, BUSY,   4'b0010, 1, 0, 0, 0, 0);
        add(0, 4'b0000, 4'h0, ACCESS, 4'b0010, 1, 0, 0, 0, 0);
        add(0, 4'b0000, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);
        add(0, 4'b0000, 4'h0, FREE,   4'h0,    0, 0, 0, 0, 0);

        step();
        foreach (vec[i]) begin
            nRST     = !vec[i].rst;
            req      = vec[i].req;
            blk      = vec[i].blk;
            ramstate = vec[i].rs;
            @(negedge CLK);
            chk_all(i, vec[i].gnt, vec[i].id, vec[i].beat, vec[i].bd, vec[i].xd, vec[i].er);
            step();
        end

        // Reset asserted mid-cycle while on beat 1 of a block.
        nRST = 1'b0; req = '0; blk = '0; ramstate = FREE;
        step();
        nRST = 1'b1; req = 4'b0001; blk = 4'b0001; ramstate = FREE;
        step();
        ramstate = ACCESS;
        @(negedge CLK);
        chk_all(100, 4'b0001, 0, 0, 1, 0, 0);
        step();
        ramstate = BUSY;
        @(negedge CLK);
        chk_all(101, 4'b0001, 0, 1, 0, 0, 0);
        #2 nRST = 1'b0;
        ramstate = ACCESS;
        #1;
        chk_all(102, 4'h0, 0, 0, 0, 0, 0);
        step();
        nRST = 1'b1; req = 4'b0011; blk = 4'b0000; ramstate = FREE;
        @(negedge CLK);
        chk_all(103, 4'h0, 0, 0, 0, 0, 0);
        step();
        ramstate = ACCESS;
        @(negedge CLK);
        chk_all(104, 4'b0001, 0, 0, 1, 1, 0);
        step();
        req = 4'b0000; ramstate = FREE;
        @(negedge CLK);
        chk_all(105, 4'h0, 0, 0, 0, 0, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of data grants an instruction requester may lose before it is forced to win.
REQ-002 SHALL have ports: CLK input 1, clock; nRST input 1, reset (asynchronous, active-low).
REQ-003 SHALL have port req, input, 4 bits: bit0 dcache0, bit1 icache0, bit2 dcache1, bit3 icache1; held high until xfer_done.
REQ-004 SHALL have port blk, input, 4 bits: per-requester flag, 1 = two-word block, 0 = single word; sampled at grant.
REQ-005 SHALL have port ramstate, input, ramstate_t (FREE/BUSY/ACCESS/ERROR): RAM status for the current beat.
REQ-006 SHALL have port gnt, output, 4 bits: one-hot grant, high throughout the transfer.
REQ-007 SHALL have port gnt_id, output, 2 bits: encoded index of the granted requester.
REQ-008 SHALL have port beat, output, 1 bit: word index within the block (0 then 1), used for address offset.
REQ-009 SHALL have port beat_done, output, 1 bit: high in each cycle that completes a word.
REQ-010 SHALL have port xfer_done, output, 1 bit: one-cycle pulse in the cycle the last word completes.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse when a transfer aborts on ramstate ERROR.

Function
REQ-012 SHALL implement states IDLE, XFER and TURN; there are no other states.
REQ-013 SHALL, in IDLE with any req bit set, pick a winner combinationally, register gnt, gnt_id and the beat count, and enter XFER on the next edge (request-to-grant latency of 1 cycle).
REQ-014 SHALL rank priority as follows: a starved icache first, then data requests (bits 0/2), then instruction requests (bits 1/3).
REQ-015 SHALL choose within a class round-robin, using one pointer per class; each pointer toggles to the other requester after that class wins.
REQ-016 SHALL prefer index 0 (dcache0 / icache0) in both pointers after reset.
REQ-017 SHALL keep a per-icache starve counter: it increments when a data grant is issued while that icache has req high, clears when that icache is granted, and saturates at STARVE_LIMIT.
REQ-018 SHALL treat an icache as starved when its counter equals STARVE_LIMIT; if both are starved, the instruction pointer decides.
REQ-019 SHALL complete a beat in XFER when ramstate == ACCESS: beat_done = 1 combinationally; beat advances 0->1 if blk was set at grant.
REQ-020 SHALL, on the last beat (beat 0 for a single word, beat 1 for a block), assert xfer_done with beat_done and enter TURN.
REQ-021 SHALL keep gnt high through FREE and BUSY cycles with no beat progress.
REQ-022 SHALL, on ramstate == ERROR in XFER, pulse err, suppress beat_done and xfer_done, and go to TURN; the granted requester is not retried automatically.
REQ-023 SHALL, if the granted req bit drops during XFER, abort in that cycle with no beat_done, go to TURN, and not pulse err.
REQ-024 SHALL hold gnt = 0 for exactly one cycle in TURN (bus turnaround), then return to IDLE; back-to-back grants are therefore separated by 2 idle cycles.
REQ-025 SHALL let a req rising during XFER or TURN wait; it never pre-empts a transfer in progress.
REQ-026 SHALL drive gnt = 0 and gnt_id = 0 in IDLE and TURN, and set beat to 0 in IDLE.

Reset
REQ-027 SHALL, on nRST low, immediately set state = IDLE, gnt = 0, gnt_id = 0, beat = 0, beat_done = 0, xfer_done = 0, err = 0, both round-robin pointers = 0, and both starve counters = 0.
REQ-028 SHALL drop gnt when reset asserts mid-XFER; the transfer is lost with no xfer_done and no err.

Structure
REQ-029 SHALL place arb_state_t and the requester index constants (REQ_D0=0, REQ_I0=1, REQ_D1=2, REQ_I1=3) in cpu_types_pkg; ramstate_t is reused from the same package.
REQ-030 SHALL instantiate one sub-module, starve_counter, a saturating counter with inc/clr inputs and a sat output, twice (once per icache).

Verification
REQ-031 SHALL cover: req=0001, blk=0001, ramstate BUSY,BUSY,ACCESS,BUSY,ACCESS -> gnt=0001 from cycle 1, beat_done at cycles 3 and 5, beat 0->1, xfer_done at cycle 5, gnt=0 at cycle 6.
REQ-032 SHALL cover: req=0101 held through 3 transfers, all ACCESS -> grant order dcache0, dcache1, dcache0.
REQ-033 SHALL cover: req=0111 continuous, STARVE_LIMIT=2, single-word -> icache0 granted as the 3rd transfer, after 2 data grants.
REQ-034 SHALL cover: req=1000 granted, ramstate ERROR on beat 0 -> err pulse for 1 cycle, no xfer_done, TURN, then IDLE.
REQ-035 SHALL cover: req=0010 granted, req dropped after 1 BUSY cycle -> gnt=0 the next cycle, no beat_done, no err.
REQ-036 SHALL cover: nRST asserted mid-block on beat 1 -> all outputs 0 immediately; after release with req=0011, dcache0 is granted first.
